// File: rtl/serial_mod_pkg.sv
// Shared types and helpers for the streaming divisibility checker.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package serial_mod_pkg;

   // IDLE: no digit consumed in the current frame; RUN: frame in progress.
   typedef enum logic [0:0] {IDLE, RUN} state_t;

   // Ceil-log2, used to size the remainder and weight registers.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/mod_step.sv
// One digit step of the running modulo reduction (combinational).
// Latency: 0 cycles, pure combinational.
// Backpressure: none, evaluated every cycle.
// Ports: rem/wt = stored remainder/weight (< DIVISOR), d = incoming digit,
//        rem_next/wt_next = fully reduced values after consuming d.
module mod_step
   import serial_mod_pkg::*;
#(
   parameter int DIVISOR   = 5,
   parameter int DATA_W    = 1,
   parameter bit MSB_FIRST = 1'b1,
   localparam int REM_W    = clog2(DIVISOR)
) (
   input  logic [REM_W-1:0]  rem,
   input  logic [REM_W-1:0]  wt,
   input  logic [DATA_W-1:0] d,
   output logic [REM_W-1:0]  rem_next,
   output logic [REM_W-1:0]  wt_next
);

   // One spare bit so the LSB-first sum rem + d*wt cannot overflow.
   localparam int PW = REM_W + DATA_W + 1;

   logic [PW-1:0] rem_x, wt_x, d_x, div_x;
   logic [PW-1:0] msb_sum, lsb_sum, wt_sh;

   assign rem_x   = PW'(rem);
   assign wt_x    = PW'(wt);
   assign d_x     = PW'(d);
   assign div_x   = PW'(DIVISOR);

   // MSB-first: Horner step, shift the remainder up one digit and add d.
   assign msb_sum = (rem_x << DATA_W) + d_x;
   // LSB-first: d carries weight radix^position, tracked modulo DIVISOR in wt.
   assign lsb_sum = rem_x + d_x * wt_x;
   assign wt_sh   = wt_x << DATA_W;

   always_comb begin
      rem_next = '0;
      wt_next  = wt;
      if (MSB_FIRST) begin
         rem_next = REM_W'(msb_sum % div_x);
      end else begin
         rem_next = REM_W'(lsb_sum % div_x);
         wt_next  = REM_W'(wt_sh % div_x);
      end
   end

endmodule

// File: rtl/serial_mod_checker.sv
// Streaming divisibility checker: running remainder of a framed digit stream modulo DIVISOR.
// Latency: result_valid one cycle after the edge sampling the in_valid & in_last beat.
// Backpressure: none, every in_valid beat is consumed (one digit per cycle).
// Ports: CLK/nRST clock and async active-low reset; clear aborts the frame;
//        in_valid/in_data/in_last digit stream; accept = running rem is 0;
//        busy = frame in progress; result_* = one-cycle pulse plus held frame result.
module serial_mod_checker
   import serial_mod_pkg::*;
#(
   parameter int DIVISOR   = 5,
   parameter int DATA_W    = 1,
   parameter bit MSB_FIRST = 1'b1,
   parameter int CNT_W     = 16,
   localparam int REM_W    = clog2(DIVISOR)
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              clear,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              accept,
   output logic              busy,
   output logic              result_valid,
   output logic [REM_W-1:0]  result_rem,
   output logic              result_div,
   output logic [CNT_W-1:0]  result_len
);

   localparam logic [CNT_W-1:0] LEN_MAX = {CNT_W{1'b1}};
   localparam logic [REM_W-1:0] WT_ONE  = REM_W'(1);

   state_t           state;
   logic [REM_W-1:0] rem, wt;
   logic [REM_W-1:0] rem_next, wt_next;
   logic [CNT_W-1:0] len, len_next;

   mod_step #(
      .DIVISOR   (DIVISOR),
      .DATA_W    (DATA_W),
      .MSB_FIRST (MSB_FIRST)
   ) u_step (
      .rem      (rem),
      .wt       (wt),
      .d        (in_data),
      .rem_next (rem_next),
      .wt_next  (wt_next)
   );

   // Saturating digit count.
   assign len_next = (len == LEN_MAX) ? len : len + CNT_W'(1);

   // rem is forced to 0 whenever the frame restarts, so accept is 1 in IDLE.
   assign accept = (rem == '0);
   assign busy   = (state == RUN);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state        <= IDLE;
         rem          <= '0;
         wt           <= WT_ONE;
         len          <= '0;
         result_valid <= 1'b0;
         result_rem   <= '0;
         result_div   <= 1'b0;
         result_len   <= '0;
      end else begin
         result_valid <= 1'b0;
         if (clear) begin
            // Abort wins over a same-cycle digit: the digit is dropped.
            state <= IDLE;
            rem   <= '0;
            wt    <= WT_ONE;
            len   <= '0;
         end else if (in_valid) begin
            // IDLE and RUN share transitions: last closes the frame, otherwise run on.
            if (in_last) begin
               state        <= IDLE;
               rem          <= '0;
               wt           <= WT_ONE;
               len          <= '0;
               result_valid <= 1'b1;
               result_rem   <= rem_next;
               result_div   <= (rem_next == '0);
               result_len   <= len_next;
            end else begin
               state <= RUN;
               rem   <= rem_next;
               wt    <= wt_next;
               len   <= len_next;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_mod_checker.sv
// Self-checking bench: five differently parametrised checkers share one digit stream.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_serial_mod_checker;

   logic       CLK, nRST, clear, in_valid, in_last;
   logic [3:0] in_data;

   // Instance k outputs: 0 = D5/W1/MSB, 1 = D5/W1/LSB, 2 = D7/W4/MSB,
   // 3 = D7/W4/LSB, 4 = D5/W1/MSB with a 3-bit length counter.
   logic        acc0, acc1, acc2, acc3, acc4;
   logic        bsy0, bsy1, bsy2, bsy3, bsy4;
   logic        rv0, rv1, rv2, rv3, rv4;
   logic [2:0]  rr0, rr1, rr2, rr3, rr4;
   logic        rd0, rd1, rd2, rd3, rd4;
   logic [15:0] rl0, rl1, rl2, rl3;
   logic [2:0]  rl4;

   int checks   = 0;
   int failures = 0;

   serial_mod_checker #(.DIVISOR(5), .DATA_W(1), .MSB_FIRST(1'b1), .CNT_W(16)) u_m5 (
      .CLK(CLK), .nRST(nRST), .clear(clear), .in_valid(in_valid), .in_data(in_data[0]),
      .in_last(in_last), .accept(acc0), .busy(bsy0), .result_valid(rv0),
      .result_rem(rr0), .result_div(rd0), .result_len(rl0));
   serial_mod_checker #(.DIVISOR(5), .DATA_W(1), .MSB_FIRST(1'b0), .CNT_W(16)) u_l5 (
      .CLK(CLK), .nRST(nRST), .clear(clear), .in_valid(in_valid), .in_data(in_data[0]),
      .in_last(in_last), .accept(acc1), .busy(bsy1), .result_valid(rv1),
      .result_rem(rr1), .result_div(rd1), .result_len(rl1));
   serial_mod_checker #(.DIVISOR(7), .DATA_W(4), .MSB_FIRST(1'b1), .CNT_W(16)) u_m7 (
      .CLK(CLK), .nRST(nRST), .clear(clear), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .accept(acc2), .busy(bsy2), .result_valid(rv2),
      .result_rem(rr2), .result_div(rd2), .result_len(rl2));
   serial_mod_checker #(.DIVISOR(7), .DATA_W(4), .MSB_FIRST(1'b0), .CNT_W(16)) u_l7 (
      .CLK(CLK), .nRST(nRST), .clear(clear), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .accept(acc3), .busy(bsy3), .result_valid(rv3),
      .result_rem(rr3), .result_div(rd3), .result_len(rl3));
   serial_mod_checker #(.DIVISOR(5), .DATA_W(1), .MSB_FIRST(1'b1), .CNT_W(3)) u_s5 (
      .CLK(CLK), .nRST(nRST), .clear(clear), .in_valid(in_valid), .in_data(in_data[0]),
      .in_last(in_last), .accept(acc4), .busy(bsy4), .result_valid(rv4),
      .result_rem(rr4), .result_div(rd4), .result_len(rl4));

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Reference model: the frame value is kept as a plain integer and reduced only when observed.
   int              md  [5] = '{5, 5, 7, 7, 5};
   int              mw  [5] = '{1, 1, 4, 4, 1};
   bit              mmsb[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   int              mcap[5] = '{65535, 65535, 65535, 65535, 7};
   longint unsigned mval[5];
   int              mn  [5];
   bit              mfr [5];
   bit              erv [5];
   int              erem[5], ediv[5], elen[5];

   task automatic chk(input string name, input int k, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s inst%0d got=%0d expected=%0d at %0t", name, k, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 5; k++) begin
         mval[k] = 0; mn[k] = 0; mfr[k] = 0; erv[k] = 0;
         erem[k] = 0; ediv[k] = 0; elen[k] = 0;
      end
   endtask

   task automatic model_step(input bit v, input logic [3:0] d, input bit l, input bit c);
      longint unsigned dd;
      for (int k = 0; k < 5; k++) begin
         erv[k] = 0;
         dd = (mw[k] == 1) ? longint'(d[0]) : longint'(d);
         if (c) begin
            mval[k] = 0; mn[k] = 0; mfr[k] = 0;
         end else if (v) begin
            if (mmsb[k]) mval[k] = mval[k] * (64'd1 << mw[k]) + dd;
            else         mval[k] = mval[k] + (dd << (mw[k] * mn[k]));
            mn[k]++;
            if (l) begin
               erv[k]  = 1;
               erem[k] = int'(mval[k] % longint'(md[k]));
               ediv[k] = (erem[k] == 0) ? 1 : 0;
               elen[k] = (mn[k] > mcap[k]) ? mcap[k] : mn[k];
               mval[k] = 0; mn[k] = 0; mfr[k] = 0;
            end else begin
               mfr[k] = 1;
            end
         end
      end
   endtask

   task automatic check_all();
      logic        a_acc[5], a_bsy[5], a_rv[5], a_rd[5];
      logic [2:0]  a_rr[5];
      logic [15:0] a_rl[5];
      a_acc = '{acc0, acc1, acc2, acc3, acc4};
      a_bsy = '{bsy0, bsy1, bsy2, bsy3, bsy4};
      a_rv  = '{rv0, rv1, rv2, rv3, rv4};
      a_rd  = '{rd0, rd1, rd2, rd3, rd4};
      a_rr  = '{rr0, rr1, rr2, rr3, rr4};
      a_rl  = '{rl0, rl1, rl2, rl3, 16'(rl4)};
      for (int k = 0; k < 5; k++) begin
         chk("result_valid", k, int'(a_rv[k]), int'(erv[k]));
         chk("result_rem",   k, int'(a_rr[k]), erem[k]);
         chk("result_div",   k, int'(a_rd[k]), ediv[k]);
         chk("result_len",   k, int'(a_rl[k]), elen[k]);
         chk("accept",       k, int'(a_acc[k]), (mval[k] % longint'(md[k]) == 0) ? 1 : 0);
         chk("busy",         k, int'(a_bsy[k]), int'(mfr[k]));
      end
   endtask

   task automatic beat(input bit v, input logic [3:0] d, input bit l, input bit c);
      in_valid = v; in_data = d; in_last = l; clear = c;
      @(posedge CLK);
      model_step(v, d, l, c);
      #1;
      check_all();
   endtask

   // Directed frames; digit i sits in dig[4i+3:4i]. Expected remainders per instance.
   typedef struct {
      int          nd;
      logic [39:0] dig;
      int          rm5, rl5, rm7, rl7, len, len3;
   } vec_t;

   vec_t tbl[7];

   initial begin
      logic [3:0] d;
      bit         v, l, c;

      tbl[0] = '{4, 40'h0101,      0, 0, 3, 5, 4, 4};
      tbl[1] = '{3, 40'h111,       2, 2, 0, 0, 3, 3};
      tbl[2] = '{1, 40'h0,         0, 0, 0, 0, 1, 1};
      tbl[3] = '{4, 40'h1111,      0, 0, 1, 1, 4, 4};
      tbl[4] = '{3, 40'h110,       3, 1, 3, 6, 3, 3};
      tbl[5] = '{2, 40'hFF,        3, 3, 3, 3, 2, 2};
      tbl[6] = '{9, 40'h111001101, 4, 1, 2, 6, 9, 7};

      nRST = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      check_all();
      nRST = 1'b1;

      // Back-to-back frames, each first digit straight after the previous last.
      for (int i = 0; i < 7; i++) begin
         for (int j = 0; j < tbl[i].nd; j++) begin
            d = tbl[i].dig[4*j +: 4];
            beat(1'b1, d, (j == tbl[i].nd - 1), 1'b0);
         end
         chk("tbl_valid", i, int'(rv0), 1);
         chk("tbl_rem_m5", i, int'(rr0), tbl[i].rm5);
         chk("tbl_div_m5", i, int'(rd0), (tbl[i].rm5 == 0) ? 1 : 0);
         chk("tbl_rem_l5", i, int'(rr1), tbl[i].rl5);
         chk("tbl_rem_m7", i, int'(rr2), tbl[i].rm7);
         chk("tbl_rem_l7", i, int'(rr3), tbl[i].rl7);
         chk("tbl_len",    i, int'(rl0), tbl[i].len);
         chk("tbl_rem_sat", i, int'(rr4), tbl[i].rm5);
         chk("tbl_len_sat", i, int'(rl4), tbl[i].len3);
      end
      beat(1'b0, 4'h0, 1'b0, 1'b0);
      chk("pulse_one_cycle", 0, int'(rv0), 0);
      chk("result_hold", 0, int'(rr0), 4);

      // clear with the second digit: digit dropped, no result, frame restarts.
      beat(1'b1, 4'h1, 1'b0, 1'b0);
      beat(1'b1, 4'h0, 1'b1, 1'b1);
      chk("clear_busy", 0, int'(bsy0), 0);
      chk("clear_no_result", 0, int'(rv0), 0);
      beat(1'b1, 4'h1, 1'b0, 1'b0);
      beat(1'b1, 4'h0, 1'b0, 1'b0);
      beat(1'b1, 4'h1, 1'b1, 1'b0);
      chk("after_clear_rem", 0, int'(rr0), 0);
      chk("after_clear_len", 0, int'(rl0), 3);

      // in_last without in_valid is ignored.
      beat(1'b1, 4'h1, 1'b0, 1'b0);
      beat(1'b0, 4'h0, 1'b1, 1'b0);
      chk("last_no_valid", 0, int'(rv0), 0);
      beat(1'b1, 4'h1, 1'b1, 1'b0);

      // Mid-frame asynchronous reset: outputs return to reset values without a clock edge.
      beat(1'b1, 4'h1, 1'b0, 1'b0);
      beat(1'b1, 4'h1, 1'b0, 1'b0);
      nRST = 1'b0;
      #2;
      model_reset();
      check_all();
      chk("rst_accept", 0, int'(acc0), 1);
      chk("rst_busy", 0, int'(bsy0), 0);
      #2;
      nRST = 1'b1;

      // Random stream, including clears, idles and stray in_last.
      for (int n = 0; n < 600; n++) begin
         v = ($urandom_range(0, 3) != 0);
         l = ($urandom_range(0, 4) == 0) || (mn[0] >= 12);
         c = ($urandom_range(0, 29) == 0);
         d = 4'($urandom_range(0, 15));
         beat(v, d, l, c);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
